// File: rtl/inst_sequencer.sv
// Instruction buffer and issue sequencer feeding the PE control decoder.
// The host loads a program; on start it is replayed loop_cnt times, then drained before done.
module inst_sequencer #(
    parameter int INST_W = 64,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int GAP    = 0,
    parameter int DRAIN  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_v,
    output logic              prog_rdy,
    input  logic [INST_W-1:0] prog_inst,
    input  logic              prog_last,
    input  logic              clear,
    input  logic              start,
    input  logic [7:0]        loop_cnt,
    output logic              inst_v,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   prog_len
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_MAX    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W + 1)'(1);
    localparam logic [7:0]        GAP_LAST   = 8'(GAP - 1);
    localparam logic [7:0]        DRAIN_LAST = 8'(DRAIN - 1);
    localparam logic              GAP_EN     = (GAP != 0);

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   wr_ptr_r, wr_ptr_s;
    logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_s;
    logic [ADDR_W:0]     prog_len_r, prog_len_s;
    logic [7:0]          passes_r, passes_s;
    logic [7:0]          cnt_r, cnt_s;
    logic                inst_v_r, inst_v_s;
    logic [INST_W-1:0]   inst_r, inst_s;
    logic                done_r, done_s;
    logic                busy_r, busy_s;
    logic                prog_rdy_r, prog_rdy_s;
    logic                wr_en_s;
    logic                pass_end_s;
    logic [INST_W-1:0]   mem_r [DEPTH];

    assign prog_rdy = prog_rdy_r;
    assign inst_v   = inst_v_r;
    assign inst     = inst_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign prog_len = prog_len_r;

    // Next-state, pointer and registered-output computation; clear overrides everything.
    always_comb begin
        state_s    = state_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        prog_len_s = prog_len_r;
        passes_s   = passes_r;
        cnt_s      = 8'd0;
        inst_v_s   = 1'b0;
        inst_s     = '0;
        done_s     = 1'b0;
        wr_en_s    = 1'b0;
        pass_end_s = ({1'b0, rd_ptr_r} == (prog_len_r - LEN_ONE));
        if (clear) begin
            state_s    = S_IDLE;
            wr_ptr_s   = '0;
            rd_ptr_s   = '0;
            prog_len_s = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (prog_v && prog_rdy_r) begin
                        wr_en_s = 1'b1;
                        if (prog_last || (wr_ptr_r == PTR_MAX)) begin
                            prog_len_s = {1'b0, wr_ptr_r} + LEN_ONE;
                            wr_ptr_s   = '0;
                            state_s    = S_READY;
                        end else begin
                            wr_ptr_s = wr_ptr_r + PTR_ONE;
                        end
                    end else begin
                        wr_ptr_s = wr_ptr_r;
                    end
                end
                S_READY: begin
                    if (start) begin
                        rd_ptr_s = '0;
                        passes_s = (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
                        state_s  = S_RUN;
                    end else begin
                        state_s = S_READY;
                    end
                end
                S_RUN: begin
                    inst_v_s = 1'b1;
                    inst_s   = mem_r[rd_ptr_r];
                    if (pass_end_s) begin
                        rd_ptr_s = '0;
                        if (passes_r > 8'd1) begin
                            passes_s = passes_r - 8'd1;
                            state_s  = GAP_EN ? S_GAP : S_RUN;
                        end else begin
                            state_s = S_DRAIN;
                        end
                    end else begin
                        rd_ptr_s = rd_ptr_r + PTR_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_s = S_RUN;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_r == DRAIN_LAST) begin
                        done_s  = 1'b1;
                        state_s = S_READY;
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
        // busy stays up through the done cycle so it falls the cycle after done
        busy_s     = (state_s == S_RUN) || (state_s == S_GAP) || (state_s == S_DRAIN) || done_s;
        prog_rdy_s = (state_s == S_IDLE);
    end

    // State and registered outputs; async reset clears outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            prog_len_r <= '0;
            passes_r   <= 8'd0;
            cnt_r      <= 8'd0;
            inst_v_r   <= 1'b0;
            inst_r     <= '0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            prog_rdy_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            prog_len_r <= prog_len_s;
            passes_r   <= passes_s;
            cnt_r      <= cnt_s;
            inst_v_r   <= inst_v_s;
            inst_r     <= inst_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
            prog_rdy_r <= prog_rdy_s;
        end
    end

    // Program buffer storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= prog_inst;
        end
    end

endmodule

// File: tb/tb_inst_sequencer.sv
// Self-checking bench for inst_sequencer: a cycle-indexed expected-output timeline
// built from program contents and pass counts, plus hand-computed spot checks.
module tb_inst_sequencer;

    localparam int W     = 64;
    localparam int DEPTH = 16;
    localparam int G     = 2;
    localparam int DR    = 6;
    localparam int NC    = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prog_v;
    logic          prog_rdy;
    logic [W-1:0]  prog_inst;
    logic          prog_last;
    logic          clear;
    logic          start;
    logic [7:0]    loop_cnt;
    logic          inst_v;
    logic [W-1:0]  inst;
    logic          busy;
    logic          done;
    logic [4:0]    prog_len;

    inst_sequencer #(.INST_W(W), .DEPTH(DEPTH), .ADDR_W(4), .GAP(G), .DRAIN(DR)) dut (
        .clk(clk), .rst_n(rst_n), .prog_v(prog_v), .prog_rdy(prog_rdy),
        .prog_inst(prog_inst), .prog_last(prog_last), .clear(clear), .start(start),
        .loop_cnt(loop_cnt), .inst_v(inst_v), .inst(inst), .busy(busy), .done(done),
        .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) n_done <= n_done + 1;

    // expected timeline, indexed by cycle
    logic         e_v [NC];
    logic [W-1:0] e_i [NC];
    logic         e_d [NC];
    logic         e_b [NC];
    logic         e_r [NC];
    logic [4:0]   e_l [NC];

    // program-level model
    logic [W-1:0] m_prog [DEPTH];
    int  m_cnt = 0;
    int  m_len = 0;
    bit  m_idle = 1'b1;
    bit  m_loaded = 1'b0;
    int  m_free = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic fill_idle(input int from);
        for (int k = from; k < NC; k++) begin
            e_v[k] = 1'b0; e_i[k] = '0; e_d[k] = 1'b0;
            e_b[k] = 1'b0; e_r[k] = 1'b1; e_l[k] = 5'd0;
        end
    endtask

    task automatic model_reset(input int from);
        fill_idle(from);
        m_idle = 1'b1; m_loaded = 1'b0; m_cnt = 0; m_len = 0; m_free = 0;
    endtask

    // Expected issue schedule: passes of the program separated by G idle cycles, then drain.
    task automatic schedule(input int t0, input int passes);
        int t;
        t = t0 + 2;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < m_len; i++) begin
                e_v[t] = 1'b1; e_i[t] = m_prog[i]; t++;
            end
            if (p < passes - 1) t += G;
        end
        e_d[t - 1 + DR] = 1'b1;
        for (int k = t0 + 1; k <= t - 1 + DR; k++) e_b[k] = 1'b1;
        m_free = t + DR;
    endtask

    task automatic model_step(input logic pv, input logic [W-1:0] pi, input logic pl,
                              input logic st, input logic [7:0] lc, input logic cl);
        int c;
        c = cyc;
        if (cl) begin
            model_reset(c + 1);
        end else begin
            if (pv && m_idle) begin
                m_prog[m_cnt] = pi;
                m_cnt++;
                if (pl || m_cnt == DEPTH) begin
                    m_idle = 1'b0; m_loaded = 1'b1; m_len = m_cnt; m_cnt = 0;
                    for (int k = c + 1; k < NC; k++) begin
                        e_r[k] = 1'b0; e_l[k] = 5'(m_len);
                    end
                end
            end
            if (st && m_loaded && c >= m_free) begin
                schedule(c, (lc == 8'd0) ? 1 : int'(lc));
            end
        end
    endtask

    task automatic drive(input logic pv, input logic [W-1:0] pi, input logic pl,
                         input logic st, input logic [7:0] lc, input logic cl);
        @(posedge clk);
        #1;
        prog_v = pv; prog_inst = pi; prog_last = pl;
        start = st; loop_cnt = lc; clear = cl;
        if (rst_n) model_step(pv, pi, pl, st, lc, cl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic load_abc();
        drive(1'b1, 64'hA0A0_0000_0000_000A, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 64'hB0B0_0000_0000_000B, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 64'hC0C0_0000_0000_000C, 1'b1, 1'b0, 8'd0, 1'b0);
    endtask

    // Per-cycle comparison of every output against the expected timeline.
    always @(negedge clk) begin
        if (cyc < NC) begin
            chk("inst_v",   inst_v,   e_v[cyc]);
            chk("inst",     inst,     e_i[cyc]);
            chk("done",     done,     e_d[cyc]);
            chk("busy",     busy,     e_b[cyc]);
            chk("prog_rdy", prog_rdy, e_r[cyc]);
            chk("prog_len", prog_len, e_l[cyc]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        logic [7:0] pat;
        rst_n = 1'b0;
        prog_v = 1'b0; prog_inst = '0; prog_last = 1'b0;
        clear = 1'b0; start = 1'b0; loop_cnt = 8'd0;
        model_reset(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_v", inst_v, 1'b0);
        chk("rst_prog_rdy", prog_rdy, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_prog_len", prog_len, 5'd0);
        rst_n = 1'b1;

        // 1: single pass of A,B,C with literal timing pins
        load_abc();
        idle(1);
        chk("t1_prog_rdy_low", prog_rdy, 1'b0);
        chk("t1_prog_len", prog_len, 5'd3);
        drive(1'b0, '0, 1'b0, 1'b1, 8'd1, 1'b0);
        idle(1);
        chk("t1_busy_T1", busy, 1'b1);
        chk("t1_noinst_T1", inst_v, 1'b0);
        idle(1);
        chk("t1_first_inst", inst, 64'hA0A0_0000_0000_000A);
        idle(8);
        chk("t1_done_T10", done, 1'b1);
        chk("t1_busy_T10", busy, 1'b1);
        idle(1);
        chk("t1_busy_T11", busy, 1'b0);
        chk("t1_done_T11", done, 1'b0);

        // 2: two passes with gap
        d0 = n_done;
        drive(1'b0, '0, 1'b0, 1'b1, 8'd2, 1'b0);
        idle(1);
        pat = 8'd0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            pat = {pat[6:0], inst_v};
        end
        idle(15);
        chk("t2_pattern", pat, 8'b1110_0111);
        chk("t2_one_done", n_done - d0, 1);

        // 3: fill all 16 entries without prog_last, then a 17th word
        drive(1'b0, '0, 1'b0, 1'b0, 8'd0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 64'h3000 + i, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1'b1, 64'hDEAD, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("t3_rdy_full", prog_rdy, 1'b0);
        chk("t3_len16", prog_len, 5'd16);
        drive(1'b0, '0, 1'b0, 1'b1, 8'd1, 1'b0);
        idle(26);

        // 4: loop_cnt=0, ignored starts, re-start
        drive(1'b0, '0, 1'b0, 1'b1, 8'd0, 1'b0);
        idle(2);
        drive(1'b0, '0, 1'b0, 1'b1, 8'd5, 1'b0);
        idle(25);
        drive(1'b0, '0, 1'b0, 1'b1, 8'd1, 1'b0);
        idle(25);
        drive(1'b0, '0, 1'b0, 1'b0, 8'd0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1, 8'd1, 1'b0);
        idle(3);
        chk("t4_idle_start_ignored", busy, 1'b0);

        // 5a: clear while B is on the output
        load_abc();
        d0 = n_done;
        drive(1'b0, '0, 1'b0, 1'b1, 8'd1, 1'b0);
        idle(2);
        drive(1'b0, '0, 1'b0, 1'b0, 8'd0, 1'b1);
        idle(1);
        chk("t5_clear_inst_v", inst_v, 1'b0);
        chk("t5_clear_inst", inst, 64'd0);
        chk("t5_clear_rdy", prog_rdy, 1'b1);
        idle(12);
        chk("t5_no_done", n_done - d0, 0);

        // 5b: async reset while in the gap between passes
        load_abc();
        drive(1'b0, '0, 1'b0, 1'b1, 8'd2, 1'b0);
        idle(4);
        rst_n = 1'b0;
        model_reset(cyc);
        #1;
        chk("t5_arst_inst_v", inst_v, 1'b0);
        chk("t5_arst_inst", inst, 64'd0);
        chk("t5_arst_busy", busy, 1'b0);
        chk("t5_arst_rdy", prog_rdy, 1'b1);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // 6: random prog_v, five-word program, then replay
        for (int i = 0; i < 100 && m_idle; i++) begin
            logic pv;
            pv = 1'($urandom_range(0, 1));
            drive(pv, 64'h6000 + i, pv && (m_cnt == 4), 1'b0, 8'd0, 1'b0);
        end
        idle(1);
        chk("t6_len5", prog_len, 5'd5);
        drive(1'b0, '0, 1'b0, 1'b1, 8'd1, 1'b0);
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
